// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array job arbiter and its array driver.
// One-hot state encoding so both sides can decode a single bit per phase.
package sa_pkg;

    localparam int state_width_lp = 5;

    typedef enum logic [state_width_lp-1:0] {
        IDLE  = 5'b00001,
        FEED  = 5'b00010,
        WAIT  = 5'b00100,
        FLUSH = 5'b01000,
        DRAIN = 5'b10000
    } sa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: first valid requester at or above ptr, wrapping.
// Purely combinational; the pointer is owned by the caller.
module rr_arbiter #(
    parameter int num_req_p = 2
) (
    input  logic [num_req_p-1:0]         valid,
    input  logic [$clog2(num_req_p)-1:0] ptr,
    output logic [$clog2(num_req_p)-1:0] idx,
    output logic                         any
);

    localparam int idx_w_lp = $clog2(num_req_p);
    localparam logic [idx_w_lp:0] num_lp = (idx_w_lp+1)'(num_req_p);

    logic [idx_w_lp-1:0]  cand [num_req_p];
    logic [num_req_p-1:0] hit;

    // Candidate at search offset gi is (ptr + gi) mod num_req_p.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_cand
        logic [idx_w_lp:0] sum;
        assign sum      = {1'b0, ptr} + (idx_w_lp+1)'(gi);
        assign cand[gi] = (sum >= num_lp) ? idx_w_lp'(sum - num_lp) : sum[idx_w_lp-1:0];
        assign hit[gi]  = valid[cand[gi]];
    end

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_job_arbiter.sv
// Grants one requester at a time exclusive use of the systolic array driver for a
// full job: operand feed, compute wait, flush, and result drain, all pass-through.
module sa_job_arbiter
    import sa_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int num_req_p     = 2,
    parameter int num_results_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_req_p-1:0]         req_valid_i,
    input  logic [num_req_p*width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]         req_last_i,
    output logic [num_req_p-1:0]         req_ready_o,
    output logic [num_req_p-1:0]         res_valid_o,
    output logic [width_p-1:0]           res_data_o,
    input  logic [num_req_p-1:0]         res_yumi_i,
    output logic                         sa_valid_o,
    output logic [width_p-1:0]           sa_data_o,
    input  logic                         sa_ready_i,
    output logic                         sa_flush_o,
    input  logic                         sa_busy_i,
    input  logic                         sa_valid_i,
    input  logic [width_p-1:0]           sa_data_i,
    output logic                         sa_yumi_o,
    output logic [$clog2(num_req_p)-1:0] grant_o
);

    localparam int idx_w_lp = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(num_results_p + 1);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(num_results_p - 1);
    localparam logic [idx_w_lp-1:0] max_idx_lp  = idx_w_lp'(num_req_p - 1);

    sa_state_e           state_reg, state_next;
    logic [idx_w_lp-1:0] grant_reg, grant_next;
    logic [idx_w_lp-1:0] rr_ptr_reg, rr_ptr_next;
    logic                busy_seen_reg, busy_seen_next;
    logic [cnt_w_lp-1:0] cnt_reg, cnt_next;

    logic [idx_w_lp-1:0] win_idx;
    logic                win_any;
    logic                owner_valid;
    logic                owner_last;
    logic [width_p-1:0]  owner_data;
    logic                res_fire;

    rr_arbiter #(
        .num_req_p (num_req_p)
    ) u_rr_arbiter (
        .valid (req_valid_i),
        .ptr   (rr_ptr_reg),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign owner_valid = req_valid_i[grant_reg];
    assign owner_last  = req_last_i[grant_reg];
    assign owner_data  = req_data_i[grant_reg*width_p +: width_p];
    assign res_fire    = (state_reg == DRAIN) && sa_valid_i && res_yumi_i[grant_reg];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            busy_seen_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            busy_seen_reg <= busy_seen_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        busy_seen_next = busy_seen_reg;
        cnt_next       = cnt_reg;
        req_ready_o    = '0;
        res_valid_o    = '0;
        res_data_o     = '0;
        sa_valid_o     = 1'b0;
        sa_data_o      = '0;
        sa_flush_o     = 1'b0;
        sa_yumi_o      = 1'b0;
        grant_o        = grant_reg;

        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    grant_next = win_idx;
                    state_next = FEED;
                end
            end
            FEED: begin
                sa_valid_o             = owner_valid;
                sa_data_o              = owner_data;
                req_ready_o[grant_reg] = sa_ready_i;
                if (owner_valid && sa_ready_i && owner_last) begin
                    busy_seen_next = 1'b0;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                // Flush only once the array has been seen busy and has gone idle again.
                if (sa_busy_i) begin
                    busy_seen_next = 1'b1;
                end
                if (busy_seen_reg && !sa_busy_i && sa_ready_i) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                sa_flush_o = 1'b1;
                cnt_next   = '0;
                state_next = DRAIN;
            end
            DRAIN: begin
                res_valid_o[grant_reg] = sa_valid_i;
                res_data_o             = sa_data_i;
                sa_yumi_o              = res_fire;
                if (res_fire) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == last_cnt_lp) begin
                        state_next  = IDLE;
                        rr_ptr_next = (grant_reg == max_idx_lp) ? '0 : grant_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sa_job_arbiter.sv
// Directed bench for sa_job_arbiter: job-level model checked every cycle, plus
// literal expectations on word order, grant order, flush and result counts.
module tb_sa_job_arbiter;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int NR = 4;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   res_valid_o;
    logic [W-1:0]   res_data_o;
    logic [N-1:0]   res_yumi_i;
    logic           sa_valid_o;
    logic [W-1:0]   sa_data_o;
    logic           sa_ready_i;
    logic           sa_flush_o;
    logic           sa_busy_i;
    logic           sa_valid_i;
    logic [W-1:0]   sa_data_i;
    logic           sa_yumi_o;
    logic [$clog2(N)-1:0] grant_o;

    always #5 clk_i = ~clk_i;

    sa_job_arbiter #(.width_p(W), .num_req_p(N), .num_results_p(NR)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_yumi_i(res_yumi_i), .sa_valid_o(sa_valid_o), .sa_data_o(sa_data_o),
        .sa_ready_i(sa_ready_i), .sa_flush_o(sa_flush_o), .sa_busy_i(sa_busy_i),
        .sa_valid_i(sa_valid_i), .sa_data_i(sa_data_i), .sa_yumi_o(sa_yumi_o),
        .grant_o(grant_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Stimulus state: per-requester pending words {last, data}
    logic [32:0] rq0[$];
    logic [32:0] rq1[$];
    bit toggle_ready = 0;
    bit yumi_en      = 0;
    bit chk_en       = 0;
    int res_idx      = 0;

    // Observation logs
    logic [31:0] sa_log[$];
    logic [31:0] res_log[$];
    int          res_owner_log[$];
    int          grant_log[$];
    int          flush_cnt = 0;
    int          last_cnt  = 0;

    // Job-level model: phase 0 idle, 1 operands, 2 compute, 3 flush, 4 results
    int m_phase = 0, m_owner = 0, m_ptr = 0, m_seen = 0, m_cnt = 0;
    bit m_found;

    always @(posedge clk_i) begin
        if (reset_i) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_seen = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!m_found && req_valid_i[(m_ptr + k) % N]) begin
                            m_found = 1;
                            m_owner = (m_ptr + k) % N;
                        end
                    end
                    if (m_found) m_phase = 1;
                end
                1: if (req_valid_i[m_owner] && sa_ready_i && req_last_i[m_owner]) begin
                    m_phase = 2;
                    m_seen  = 0;
                end
                2: begin
                    if (m_seen != 0 && !sa_busy_i && sa_ready_i) m_phase = 3;
                    if (sa_busy_i) m_seen = 1;
                end
                3: begin
                    m_phase = 4;
                    m_cnt   = 0;
                end
                4: if (res_yumi_i[m_owner] && sa_valid_i) begin
                    m_cnt++;
                    if (m_cnt == NR) begin
                        m_phase = 0;
                        m_ptr   = (m_owner + 1) % N;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    logic [N-1:0] e_ready, e_rvalid;
    logic [W-1:0] e_sad, e_rdata;
    logic         e_sav, e_flush, e_yumi;

    always @(negedge clk_i) begin
        if (chk_en) begin
            e_ready  = '0;
            e_rvalid = '0;
            e_sav    = 1'b0;
            e_sad    = '0;
            e_rdata  = '0;
            e_flush  = (m_phase == 3);
            e_yumi   = 1'b0;
            if (m_phase == 1) begin
                e_ready[m_owner] = sa_ready_i;
                e_sav            = req_valid_i[m_owner];
                e_sad            = req_data_i[m_owner*W +: W];
            end
            if (m_phase == 4) begin
                e_rvalid[m_owner] = sa_valid_i;
                e_rdata           = sa_data_i;
                e_yumi            = sa_valid_i & res_yumi_i[m_owner];
            end
            chk("req_ready_o", req_ready_o, e_ready);
            chk("sa_valid_o", sa_valid_o, e_sav);
            chk("sa_data_o", sa_data_o, e_sad);
            chk("sa_flush_o", sa_flush_o, e_flush);
            chk("res_valid_o", res_valid_o, e_rvalid);
            chk("res_data_o", res_data_o, e_rdata);
            chk("sa_yumi_o", sa_yumi_o, e_yumi);
            chk("grant_o", grant_o, m_owner);
            if (sa_valid_o && sa_ready_i) begin
                sa_log.push_back(sa_data_o);
                if (req_last_i[grant_o]) begin
                    last_cnt++;
                    grant_log.push_back(int'(grant_o));
                end
            end
            if (sa_flush_o) flush_cnt++;
            if (sa_yumi_o) begin
                res_log.push_back(res_data_o);
                res_owner_log.push_back(int'(grant_o));
            end
        end
    end

    task automatic present();
        req_valid_i[0]     = (rq0.size() > 0);
        req_last_i[0]      = (rq0.size() > 0) ? rq0[0][32] : 1'b0;
        req_data_i[W-1:0]  = (rq0.size() > 0) ? rq0[0][31:0] : '0;
        req_valid_i[1]     = (rq1.size() > 0);
        req_last_i[1]      = (rq1.size() > 0) ? rq1[0][32] : 1'b0;
        req_data_i[2*W-1:W] = (rq1.size() > 0) ? rq1[0][31:0] : '0;
        sa_data_i          = 32'hC0 + 32'(res_idx);
    endtask

    task automatic step();
        bit a0, a1, y;
        @(negedge clk_i);
        a0 = req_valid_i[0] & req_ready_o[0];
        a1 = req_valid_i[1] & req_ready_o[1];
        y  = sa_yumi_o;
        @(posedge clk_i);
        #1;
        if (a0 && rq0.size() > 0) void'(rq0.pop_front());
        if (a1 && rq1.size() > 0) void'(rq1.pop_front());
        if (y) res_idx++;
        if (toggle_ready) sa_ready_i = ~sa_ready_i;
        present();
        #1;
        res_yumi_i = yumi_en ? res_valid_o : '0;
    endtask

    task automatic push_job(input int r, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if (r == 0) rq0.push_back({(i == n - 1), base + 32'(i)});
            else        rq1.push_back({(i == n - 1), base + 32'(i)});
        end
        present();
    endtask

    task automatic wait_last(input int bound);
        int target = last_cnt + 1;
        int c = 0;
        while (last_cnt < target && c < bound) begin
            step();
            c++;
        end
        chk("feed_done", last_cnt, target);
    endtask

    // Array-driver side of one job after its last operand word.
    task automatic serve(input int busy_delay, input int busy_len, input int stall, input int nres);
        int f0 = flush_cnt;
        int r0 = res_log.size();
        int c;
        toggle_ready = 0;
        sa_ready_i   = 1'b1;
        sa_valid_i   = 1'b1;
        yumi_en      = (stall == 0);
        sa_busy_i    = 1'b0;
        repeat (busy_delay) step();
        if (busy_delay > 0) chk("flush_before_busy", flush_cnt, f0);
        sa_busy_i = 1'b1;
        repeat (busy_len) step();
        sa_busy_i = 1'b0;
        c = 0;
        while (flush_cnt == f0 && c < 20) begin
            step();
            c++;
        end
        chk("flush_count", flush_cnt, f0 + 1);
        if (stall > 0) begin
            repeat (stall) begin
                step();
                chk("stall_no_result", res_log.size(), r0);
            end
            chk("stall_res_valid", res_valid_o, N'(1) << m_owner);
            yumi_en    = 1;
            res_yumi_i = res_valid_o;
        end
        c = 0;
        while (res_log.size() < r0 + nres && c < 50) begin
            step();
            c++;
        end
        chk("result_count", res_log.size(), r0 + nres);
        if (nres == NR) begin
            sa_valid_i = 1'b0;
            yumi_en    = 0;
        end
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        yumi_en    = 0;
        sa_valid_i = 1'b0;
        res_yumi_i = '0;
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        int ls, rs, gs, f0;
        reset_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0;
        res_yumi_i = '0; sa_ready_i = 1'b1; sa_busy_i = 1'b0; sa_valid_i = 1'b0;
        sa_data_i = '0;
        @(posedge clk_i);
        #1;
        chk_en = 1;
        step();
        step();
        reset_i = 1'b0;
        chk("rst_grant", grant_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_sa_valid", sa_valid_o, 0);
        chk("rst_res_data", res_data_o, 0);

        // Single job on requester 0
        ls = sa_log.size(); rs = res_log.size();
        push_job(0, 4, 32'hA0);
        wait_last(40);
        serve(0, 3, 0, 4);
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            chk("t1_word", sa_log[ls + i], 32'hA0 + i);
            chk("t1_result", res_log[rs + i], 32'hC0 + i);
            chk("t1_owner", res_owner_log[rs + i], 0);
        end
        chk("t1_flushes", flush_cnt, 1);
        $display("job single: words=%0d results=%0d flushes=%0d", sa_log.size() - ls, res_log.size() - rs, flush_cnt);

        // Contention from reset: expect grants 0,1,0
        do_reset();
        ls = sa_log.size(); gs = grant_log.size();
        push_job(0, 2, 32'hB0);
        push_job(1, 2, 32'hB8);
        push_job(0, 2, 32'hB2);
        for (int j = 0; j < 3; j++) begin
            wait_last(40);
            serve(0, 2, 0, 4);
        end
        chk("t2_grant0", grant_log[gs], 0);
        chk("t2_grant1", grant_log[gs + 1], 1);
        chk("t2_grant2", grant_log[gs + 2], 0);
        chk("t2_word0", sa_log[ls], 32'hB0);
        chk("t2_word1", sa_log[ls + 1], 32'hB1);
        chk("t2_word2", sa_log[ls + 2], 32'hB8);
        chk("t2_word3", sa_log[ls + 3], 32'hB9);
        chk("t2_word4", sa_log[ls + 4], 32'hB2);
        chk("t2_word5", sa_log[ls + 5], 32'hB3);
        $display("job contention: grants %0d %0d %0d", grant_log[gs], grant_log[gs + 1], grant_log[gs + 2]);

        // Backpressure: ready toggles during operand feed
        ls = sa_log.size();
        toggle_ready = 1;
        push_job(0, 4, 32'hD0);
        wait_last(40);
        serve(0, 2, 0, 4);
        chk("t3_count", sa_log.size() - ls, 4);
        for (int i = 0; i < 4; i++) chk("t3_word", sa_log[ls + i], 32'hD0 + i);
        $display("job backpressure: words=%0d", sa_log.size() - ls);

        // Result stall on requester 1
        rs = res_log.size();
        push_job(1, 1, 32'hE0);
        wait_last(40);
        serve(0, 2, 5, 4);
        for (int i = 0; i < 4; i++) chk("t4_owner", res_owner_log[rs + i], 1);
        $display("job stall: results=%0d owner=%0d", res_log.size() - rs, res_owner_log[rs]);

        // Flush waits for a busy pulse even after idle cycles
        f0 = flush_cnt;
        push_job(0, 2, 32'hF0);
        wait_last(40);
        serve(3, 1, 0, 4);
        chk("t5_flushes", flush_cnt, f0 + 1);
        $display("job wait-guard: flushes=%0d", flush_cnt - f0);

        // Reset mid-drain on requester 1 after two results
        f0 = flush_cnt; rs = res_log.size();
        push_job(1, 1, 32'h60);
        wait_last(40);
        serve(0, 1, 0, 2);
        do_reset();
        chk("t6_res_count", res_log.size(), rs + 2);
        chk("t6_flushes", flush_cnt, f0 + 1);
        chk("t6_req_ready", req_ready_o, 0);
        chk("t6_res_valid", res_valid_o, 0);
        chk("t6_sa_valid", sa_valid_o, 0);
        chk("t6_yumi", sa_yumi_o, 0);
        chk("t6_grant", grant_o, 0);
        push_job(0, 1, 32'h70);
        push_job(1, 1, 32'h78);
        step();
        chk("t6_next_grant", grant_o, 0);
        wait_last(40);
        serve(0, 2, 0, 4);
        wait_last(40);
        serve(0, 2, 0, 4);
        chk("t6_last_grant", grant_log[grant_log.size() - 1], 1);
        $display("job reset-drain: next grant=%0d", grant_log[grant_log.size() - 2]);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_job_arbiter.md
SA_JOB_ARBITER -- requirements
Module: sa_job_arbiter

Interface
REQ-001 Parameters SHALL be: width_p, default 32, data word width; num_req_p, default 2, number of requesters (2..8); num_results_p, default 4, result words per job (= array_width_p*array_height_p of the attached array).
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  num_req_p  per-requester operand word valid.
- req_data_i  in  num_req_p*width_p  per-requester operand word; requester k occupies bits [k*width_p +: width_p].
- req_last_i  in  num_req_p  marks the final operand word of a job.
- req_ready_o  out  num_req_p  operand word accepted when valid&ready.
- res_valid_o  out  num_req_p  result word valid, granted requester only.
- res_data_o  out  width_p  result word, shared by all requesters.
- res_yumi_i  in  num_req_p  result consumed; legal only while the matching res_valid_o is high.
- sa_valid_o / sa_data_o / sa_ready_i  out 1 / out width_p / in 1  operand stream to the array driver.
- sa_flush_o  out  1  single-cycle flush request to the driver.
- sa_busy_i  in  1  driver compute-busy indicator.
- sa_valid_i / sa_data_i / sa_yumi_o  in 1 / in width_p / out 1  result stream from the driver.
- grant_o  out  $clog2(num_req_p)  index of the current owner (debug).

Function
REQ-003 States SHALL be IDLE, FEED, WAIT, FLUSH, DRAIN, one-hot encoded.
REQ-004 In IDLE, if any req_valid_i is high, the arbiter SHALL latch the winner into grant_r and enter FEED on the next edge. The winner is the first requester with valid high, searching from rr_ptr_r upward with wrap-around.
REQ-005 In FEED, the arbiter SHALL set sa_valid_o=req_valid_i[grant_r], sa_data_o=req_data_i[grant_r] and req_ready_o[grant_r]=sa_ready_i, all combinational with zero latency. All other req_ready_o bits SHALL be 0.
REQ-006 In FEED, a handshake with req_last_i[grant_r]=1 SHALL move the arbiter to WAIT and clear the busy_seen_r flag.
REQ-007 In WAIT, busy_seen_r SHALL set on any cycle with sa_busy_i=1. The arbiter SHALL move to FLUSH on the first cycle with busy_seen_r=1, sa_busy_i=0 and sa_ready_i=1. WAIT SHALL last at least 2 cycles.
REQ-008 FLUSH SHALL last exactly one cycle, with sa_flush_o=1, then move to DRAIN. sa_flush_o SHALL be 0 in every other state.
REQ-009 In DRAIN, the arbiter SHALL set res_valid_o[grant_r]=sa_valid_i, res_data_o=sa_data_i and sa_yumi_o=res_yumi_i[grant_r]&sa_valid_i. All other res_valid_o bits SHALL be 0.
REQ-010 A result counter SHALL increment on each sa_yumi_o. When the num_results_p-th yumi occurs, the arbiter SHALL return to IDLE and set rr_ptr_r=grant_r+1, wrapping modulo num_req_p.
REQ-011 Requests arriving during FEED..DRAIN from non-owners SHALL be held off (ready=0) and never dropped. A requester that deasserts valid before it is granted SHALL lose nothing.
REQ-012 If the owner drops req_valid_i mid-job, FEED SHALL stall indefinitely. There SHALL be no timeout.
REQ-013 When every requester is valid continuously, grants SHALL rotate 0,1,...,num_req_p-1,0. No requester SHALL wait more than num_req_p-1 jobs.
REQ-014 res_data_o SHALL be 0 whenever the state is not DRAIN. sa_data_o SHALL be 0 whenever the state is not FEED.
REQ-015 The result counter SHALL be $clog2(num_results_p+1) bits wide and SHALL clear on entry to DRAIN.

Reset
REQ-016 While reset_i=1 at a rising edge, the arbiter SHALL set: state=IDLE, grant_r=0, rr_ptr_r=0, busy_seen_r=0, result counter=0.
REQ-017 After reset, all outputs SHALL be 0 until the first post-reset transition.
REQ-018 A reset asserted mid-job SHALL abandon the job with no flush or drain issued. The attached array is reset by the same reset_i.

Structure
REQ-019 The state enum and the one-hot encoding width SHALL live in package sa_pkg, shared with the array driver.
REQ-020 The round-robin winner search SHALL be a separate sub-module rr_arbiter, parameterised on num_req_p, taking the valid vector and rr_ptr_r and returning the index plus an any-valid flag.
REQ-021 The block SHALL contain no datapath storage. Operand and result words pass through combinationally.

Verification
REQ-022 Single job: req0 sends 4 words, last on word 4; model busy pulses for 3 cycles -> exactly one sa_flush_o pulse, then 4 results reach res_valid_o[0] only, and the arbiter is back in IDLE.
REQ-023 Contention: req0 and req1 valid together from reset -> grant_o=0 first, then 1, then 0. req1's req_ready_o stays 0 throughout job 0.
REQ-024 Backpressure: sa_ready_i toggles 1,0,1,0 during FEED -> each word is transferred once, in order, with no duplicates.
REQ-025 Result stall: res_yumi_i held 0 for 5 cycles in DRAIN -> sa_yumi_o=0, the counter holds, and the arbiter stays in DRAIN.
REQ-026 WAIT guard: sa_busy_i stays 0 for 3 cycles after last, then 1, then 0 -> sa_flush_o asserts only after the busy pulse ends.
REQ-027 Reset mid-DRAIN after 2 of 4 results -> next cycle IDLE, all outputs 0, and the next grant goes to requester 0.
